// File: rtl/latex_stream_pkg.sv
// rtl/latex_stream_pkg.sv - shared types, character constants and word lane select for the pair streamer
package latex_stream_pkg;

   localparam int CHAR_BITS = 8;
   localparam logic [CHAR_BITS-1:0] NUL_CHAR     = 8'h00;
   localparam logic [CHAR_BITS-1:0] DEF_PAD_CHAR = 8'h20;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PTR_REQ,
      S_PTR_WAIT,
      S_FETCH_L,
      S_FETCH_R,
      S_CAPT,
      S_EMIT0,
      S_EMIT1,
      S_DONE
   } state_t;

   // char0 occupies the upper half of a packed ROM word
   function automatic logic [CHAR_BITS-1:0] pick_char(input logic [2*CHAR_BITS-1:0] word,
                                                      input logic sel);
      return sel ? word[CHAR_BITS-1:0] : word[2*CHAR_BITS-1:CHAR_BITS];
   endfunction

endpackage

// File: rtl/stream_lane.sv
// rtl/stream_lane.sv - one string lane: address counter, word buffer, terminator tracking
module stream_lane
   import latex_stream_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                CHAR_W   = CHAR_BITS,
   parameter logic [CHAR_W-1:0] PAD_CHAR = DEF_PAD_CHAR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [ADDR_W-1:0]   base,
   input  logic                capture,
   input  logic [2*CHAR_W-1:0] word_in,
   input  logic                sel,
   input  logic                step,
   input  logic                advance,
   output logic [ADDR_W-1:0]   addr,
   output logic [ADDR_W-1:0]   addr_next,
   output logic                ended_now,
   output logic [CHAR_W-1:0]   beat_char
);

   logic [2*CHAR_W-1:0] word_q;
   logic                ended_q;
   logic [CHAR_W-1:0]   cur_char;

   assign cur_char  = pick_char(word_q, sel);
   assign ended_now = ended_q || (cur_char == NUL_CHAR);
   assign beat_char = ended_now ? PAD_CHAR : cur_char;

   // an ended lane freezes its address; wrap is modulo 2**ADDR_W
   always_comb begin
      addr_next = addr;
      if (load)
         addr_next = base;
      else if (advance && !ended_now)
         addr_next = addr + ADDR_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr    <= '0;
         word_q  <= '0;
         ended_q <= 1'b0;
      end else begin
         addr <= addr_next;
         if (capture)
            word_q <= word_in;
         if (load)
            ended_q <= 1'b0;
         else if (step)
            ended_q <= ended_now;
      end
   end

endmodule

// File: rtl/latex_pair_streamer.sv
// rtl/latex_pair_streamer.sv - streams aligned LHS/RHS character pairs for one pointer-ROM line
module latex_pair_streamer
   import latex_stream_pkg::*;
#(
   parameter int                LINE_W    = 6,
   parameter int                NUM_LINES = 51,
   parameter int                ADDR_W    = 8,
   parameter int                CHAR_W    = CHAR_BITS,
   parameter int                MAX_CHARS = 64,
   parameter logic [CHAR_W-1:0] PAD_CHAR  = DEF_PAD_CHAR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                repeat_en,
   input  logic [LINE_W-1:0]   line,
   output logic [LINE_W-1:0]   ptr_line,
   input  logic [2*ADDR_W-1:0] ptr_data,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [2*CHAR_W-1:0] mem_dout,
   output logic [CHAR_W-1:0]   lhs_char,
   output logic [CHAR_W-1:0]   rhs_char,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int          CNT_W       = $clog2(MAX_CHARS + 1);
   localparam logic [31:0] NUM_LINES_U = NUM_LINES;

   state_t              state;
   logic [LINE_W-1:0]   line_q;
   logic                rep_q;
   logic [CNT_W-1:0]    beat_cnt;

   logic                emit, sel, both_end, accept;
   logic [ADDR_W-1:0]   l_addr, l_addr_next, r_addr, r_addr_next;
   logic                l_end, r_end;
   logic [CHAR_W-1:0]   l_char, r_char;

   assign emit      = (state == S_EMIT0) || (state == S_EMIT1);
   assign sel       = (state == S_EMIT1);
   assign both_end  = l_end && r_end;
   assign out_valid = emit && !both_end;
   assign accept    = out_valid && out_ready;
   assign lhs_char  = out_valid ? l_char : '0;
   assign rhs_char  = out_valid ? r_char : '0;
   assign busy      = (state != S_IDLE);

   stream_lane #(.ADDR_W(ADDR_W), .CHAR_W(CHAR_W), .PAD_CHAR(PAD_CHAR)) u_lhs (
      .clk       (clk),
      .rst       (rst),
      .load      (state == S_PTR_WAIT),
      .base      (ptr_data[ADDR_W-1:0]),
      .capture   (state == S_FETCH_R),
      .word_in   (mem_dout),
      .sel       (sel),
      .step      (accept),
      .advance   (accept && sel),
      .addr      (l_addr),
      .addr_next (l_addr_next),
      .ended_now (l_end),
      .beat_char (l_char)
   );

   stream_lane #(.ADDR_W(ADDR_W), .CHAR_W(CHAR_W), .PAD_CHAR(PAD_CHAR)) u_rhs (
      .clk       (clk),
      .rst       (rst),
      .load      (state == S_PTR_WAIT),
      .base      (ptr_data[2*ADDR_W-1:ADDR_W]),
      .capture   (state == S_CAPT),
      .word_in   (mem_dout),
      .sel       (sel),
      .step      (accept),
      .advance   (accept && sel),
      .addr      (r_addr),
      .addr_next (r_addr_next),
      .ended_now (r_end),
      .beat_char (r_char)
   );

   // mem_addr is loaded one state early so ROM data lands in FETCH_R / CAPT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         line_q   <= '0;
         rep_q    <= 1'b0;
         beat_cnt <= '0;
         ptr_line <= '0;
         mem_addr <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (32'(line) >= NUM_LINES_U) begin
                     err <= 1'b1;
                  end else begin
                     line_q   <= line;
                     rep_q    <= repeat_en;
                     ptr_line <= line;
                     state    <= S_PTR_REQ;
                  end
               end
            end
            S_PTR_REQ:  state <= S_PTR_WAIT;
            S_PTR_WAIT: begin
               mem_addr <= l_addr_next;
               beat_cnt <= '0;
               state    <= S_FETCH_L;
            end
            S_FETCH_L: begin
               mem_addr <= r_addr;
               state    <= S_FETCH_R;
            end
            S_FETCH_R:  state <= S_CAPT;
            S_CAPT:     state <= S_EMIT0;
            S_EMIT0, S_EMIT1: begin
               if (both_end) begin
                  state <= S_DONE;
               end else if (accept) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  if (beat_cnt == CNT_W'(MAX_CHARS - 1)) begin
                     err   <= 1'b1;
                     state <= S_DONE;
                  end else if (state == S_EMIT0) begin
                     state <= S_EMIT1;
                  end else begin
                     mem_addr <= l_addr_next;
                     state    <= S_FETCH_L;
                  end
               end
            end
            S_DONE: begin
               done <= 1'b1;
               if (rep_q && start) begin
                  ptr_line <= line_q;
                  state    <= S_PTR_REQ;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = ^r_addr_next;

endmodule

// File: tb/tb_latex_pair_streamer.sv
// tb/tb_latex_pair_streamer.sv - scoreboard bench for latex_pair_streamer with behavioural ROMs
module tb_latex_pair_streamer;

   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   logic        clk, rst, start, repeat_en, out_ready;
   logic [5:0]  line, ptr_line;
   logic [15:0] ptr_data, mem_dout;
   logic [7:0]  mem_addr, lhs_char, rhs_char;
   logic        out_valid, busy, done, err;

   logic [15:0] ptr_rom [0:63];
   logic [15:0] crom    [0:255];

   logic [15:0] beat_q [$];
   int          ev_q   [$];
   int          checks = 0;
   int          errors = 0;
   int          beats_seen = 0;

   logic        stall_prev = 1'b0;
   logic [15:0] stall_val  = '0;

   latex_pair_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .repeat_en (repeat_en),
      .line      (line),
      .ptr_line  (ptr_line),
      .ptr_data  (ptr_data),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .lhs_char  (lhs_char),
      .rhs_char  (rhs_char),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      ptr_data <= ptr_rom[ptr_line];
      mem_dout <= crom[mem_addr];
   end

   function automatic logic [7:0] long_char(input int i);
      return 8'(8'h41 + (i % 26));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (!out_valid || {lhs_char, rhs_char} !== stall_val) begin
               errors++;
               $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", out_valid, {lhs_char, rhs_char}, stall_val);
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_val  = {lhs_char, rhs_char};
         if (out_valid && out_ready) begin
            checks++;
            beats_seen++;
            if (beat_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got %h expected none", {lhs_char, rhs_char});
            end else begin
               logic [15:0] e;
               e = beat_q.pop_front();
               if ({lhs_char, rhs_char} !== e) begin
                  errors++;
                  $display("FAIL beat: got %h expected %h", {lhs_char, rhs_char}, e);
               end
            end
         end
         if (done || err) begin
            int got, e;
            got = done ? EV_DONE : EV_ERR;
            checks++;
            if (done && err) begin
               errors++;
               $display("FAIL event: got done and err together expected one");
            end else if (ev_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got %0d expected none", got);
            end else begin
               e = ev_q.pop_front();
               if (got != e) begin
                  errors++;
                  $display("FAIL event_order: got %0d expected %0d", got, e);
               end
            end
         end
      end
   end

   task automatic start_line(input logic [5:0] l, input logic rep);
      line      = l;
      repeat_en = rep;
      start     = 1'b1;
      @(posedge clk);
      #1;
      if (!rep) start = 1'b0;
   endtask

   task automatic wait_quiet(input string name, input bit toggle, input int limit);
      int n;
      n = 0;
      while ((beat_q.size() != 0 || ev_q.size() != 0 || busy) && n < limit) begin
         @(posedge clk);
         #1;
         if (toggle) out_ready = ~out_ready;
         n++;
      end
      out_ready = 1'b1;
      chk(name, 32'(n < limit), 32'd1);
   endtask

   task automatic push_line3;
      logic [15:0] exp3 [5];
      exp3 = '{16'h7431, 16'h202F, 16'h2073, 16'h205E, 16'h2032};
      for (int i = 0; i < 5; i++) beat_q.push_back(exp3[i]);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; repeat_en = 1'b0; line = '0; out_ready = 1'b1;
      for (int i = 0; i < 64; i++)  ptr_rom[i] = '0;
      for (int i = 0; i < 256; i++) crom[i] = '0;
      ptr_rom[3] = 16'h2010;
      ptr_rom[5] = 16'h3030;
      ptr_rom[7] = 16'h3040;
      crom[8'h10] = 16'h7400;
      crom[8'h20] = 16'h312F;
      crom[8'h21] = 16'h735E;
      crom[8'h22] = 16'h3200;
      for (int k = 0; k < 35; k++) crom[8'h40 + k] = {long_char(2*k), long_char(2*k + 1)};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {out_valid, busy, done, err, lhs_char, rhs_char, ptr_line, mem_addr}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      push_line3();
      ev_q.push_back(EV_DONE);
      start_line(6'd3, 1'b0);
      chk("busy_after_start", busy, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("first_valid_latency", n, 5);
      wait_quiet("line3_complete", 1'b0, 200);

      push_line3();
      ev_q.push_back(EV_DONE);
      start_line(6'd3, 1'b0);
      wait_quiet("line3_stall_complete", 1'b1, 300);

      ev_q.push_back(EV_ERR);
      start_line(6'd51, 1'b0);
      chk("range_err_pulse", {err, busy}, 2'b10);
      @(posedge clk);
      #1;
      chk("range_err_one_cycle", {err, busy}, 2'b00);
      chk("range_no_ptr_req", ptr_line, 6'd3);
      wait_quiet("range_complete", 1'b0, 20);

      ev_q.push_back(EV_DONE);
      start_line(6'd5, 1'b0);
      wait_quiet("empty_complete", 1'b0, 100);
      chk("empty_idle", busy, 1'b0);

      for (int i = 0; i < 64; i++) beat_q.push_back({long_char(i), 8'h20});
      ev_q.push_back(EV_ERR);
      ev_q.push_back(EV_DONE);
      n = beats_seen;
      start_line(6'd7, 1'b0);
      wait_quiet("max_chars_complete", 1'b0, 1000);
      chk("max_chars_beats", beats_seen - n, 64);

      push_line3();
      ev_q.push_back(EV_DONE);
      beat_q.push_back(16'h7431);
      beat_q.push_back(16'h202F);
      n = beats_seen;
      start_line(6'd3, 1'b1);
      begin
         int t;
         t = 0;
         while (beats_seen - n < 7 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
         end
         out_ready = 1'b0;
         while (!out_valid && t < 200) begin
            @(posedge clk);
            #1;
            t++;
         end
         chk("repeat_reached_beat3", 32'(t < 200), 32'd1);
      end
      #2;
      rst = 1'b1;
      start = 1'b0;
      repeat_en = 1'b0;
      #1;
      chk("abort_outputs", {out_valid, busy, done, err, lhs_char, rhs_char, ptr_line, mem_addr}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_stays_idle", busy, 1'b0);
      chk("abort_queues_empty", 32'(beat_q.size() + ev_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
